cv32e40x_pc_target_ras: RTL

Parametrised successor to the ID-stage PC target adder. It computes branch and jump targets (JAL, branch, JALR) and adds a return address stack (RAS) of configurable depth. The RAS supplies a predicted JALR return target before the forwarded rs1 value is trusted. The block sits in the ID stage beside the controller and feeds the IF PC mux.

---
 rtl/cv32e40x_pc_target_ras.sv | 137 +++++++++++++
 1 files changed

// File: rtl/cv32e40x_pc_target_ras.sv
// ID-stage branch/jump target adder with a circular return address stack.
// The stack supplies a predicted JALR return target before forwarded rs1 is trusted.
package cv32e40x_pc_target_ras_pkg;
  typedef enum logic [1:0] {
    CT_JAL  = 2'b01,
    CT_JALR = 2'b10,
    CT_BCH  = 2'b11
  } bch_jmp_mux_e;
endpackage

module cv32e40x_pc_target_ras
  import cv32e40x_pc_target_ras_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned RAS_DEPTH  = 4,
  localparam int unsigned CNT_WIDTH = $clog2(RAS_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  bch_jmp_mux_e          bch_jmp_mux_sel_i,
  input  logic                  instr_valid_i,
  input  logic                  instr_ready_i,
  input  logic                  is_jmp_i,
  input  logic                  is_compressed_i,
  input  logic [4:0]            rd_addr_i,
  input  logic [4:0]            rs1_addr_i,
  input  logic [ADDR_WIDTH-1:0] pc_id_i,
  input  logic [ADDR_WIDTH-1:0] imm_uj_type_i,
  input  logic [ADDR_WIDTH-1:0] imm_sb_type_i,
  input  logic [ADDR_WIDTH-1:0] imm_i_type_i,
  input  logic [ADDR_WIDTH-1:0] jalr_fw_i,
  input  logic                  flush_i,
  output logic [ADDR_WIDTH-1:0] bch_target_o,
  output logic [ADDR_WIDTH-1:0] jmp_target_o,
  output logic [ADDR_WIDTH-1:0] ras_target_o,
  output logic                  ras_pred_valid_o,
  output logic [CNT_WIDTH-1:0]  ras_count_o
);

  localparam int unsigned PTR_WIDTH = $clog2(RAS_DEPTH);

  logic [ADDR_WIDTH-1:0] entry_r [RAS_DEPTH];
  logic [PTR_WIDTH-1:0]  top_r;
  logic [CNT_WIDTH-1:0]  count_r;

  logic [ADDR_WIDTH-1:0] target_s;
  logic [ADDR_WIDTH-1:0] push_val_s;
  logic [PTR_WIDTH-1:0]  top_inc_s;
  logic [PTR_WIDTH-1:0]  top_dec_s;
  logic                  rd_link_s;
  logic                  rs1_link_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  repl_s;
  logic                  commit_s;
  logic                  empty_s;
  logic                  full_s;

  // Target adder; unknown select encodings fall back to the JALR path.
  always_comb begin
    target_s = '0;
    case (bch_jmp_mux_sel_i)
      CT_JAL:  target_s = pc_id_i + imm_uj_type_i;
      CT_BCH:  target_s = pc_id_i + imm_sb_type_i;
      default: target_s = jalr_fw_i + imm_i_type_i;
    endcase
  end

  assign rd_link_s  = (rd_addr_i  == 5'd1) || (rd_addr_i  == 5'd5);
  assign rs1_link_s = (rs1_addr_i == 5'd1) || (rs1_addr_i == 5'd5);

  // Call/return classification from link-register usage.
  always_comb begin
    push_s = 1'b0;
    pop_s  = 1'b0;
    repl_s = 1'b0;
    if (is_jmp_i) begin
      case (bch_jmp_mux_sel_i)
        CT_JAL: push_s = rd_link_s;
        CT_BCH: push_s = 1'b0;
        default: begin
          if (rd_link_s && rs1_link_s) begin
            repl_s = (rd_addr_i != rs1_addr_i);
            push_s = (rd_addr_i == rs1_addr_i);
          end else begin
            push_s = rd_link_s;
            pop_s  = rs1_link_s;
          end
        end
      endcase
    end else begin
      push_s = 1'b0;
      pop_s  = 1'b0;
      repl_s = 1'b0;
    end
  end

  assign push_val_s = pc_id_i + (is_compressed_i ? ADDR_WIDTH'(2) : ADDR_WIDTH'(4));
  assign top_inc_s  = (top_r == PTR_WIDTH'(RAS_DEPTH - 1)) ? '0 : top_r + PTR_WIDTH'(1);
  assign top_dec_s  = (top_r == '0) ? PTR_WIDTH'(RAS_DEPTH - 1) : top_r - PTR_WIDTH'(1);
  assign empty_s    = (count_r == '0);
  assign full_s     = (count_r == CNT_WIDTH'(RAS_DEPTH));
  assign commit_s   = instr_valid_i && instr_ready_i && !flush_i;

  // Stack state; a full push overwrites the oldest slot because top wraps onto it.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= '0;
      top_r   <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        entry_r[i] <= '0;
      end
    end else if (flush_i) begin
      count_r <= '0;
    end else if (commit_s) begin
      if (repl_s && !empty_s) begin
        entry_r[top_r] <= push_val_s;
      end else if (push_s || repl_s) begin
        top_r            <= top_inc_s;
        entry_r[top_inc_s] <= push_val_s;
        if (!full_s) begin
          count_r <= count_r + CNT_WIDTH'(1);
        end
      end else if (pop_s && !empty_s) begin
        top_r   <= top_dec_s;
        count_r <= count_r - CNT_WIDTH'(1);
      end
    end
  end

  assign bch_target_o     = target_s;
  assign jmp_target_o     = target_s;
  assign ras_target_o     = entry_r[top_r];
  assign ras_count_o      = count_r;
  assign ras_pred_valid_o = instr_valid_i && (pop_s || repl_s) && !empty_s;

endmodule
